decode_hazard_ctrl: RTL and testbench

//   Interlock controller for the decode stage and its 32x32 register bank.
//   - Keeps a per-register scoreboard of outstanding writes.
//   - Stalls issue of the instruction in ID on RAW or WAW-overflow hazards.
//   - Holds a branch shadow and latches HALT.
//   - Sits beside the decode block: consumes IR_id, is told of register-bank writes on the wb_* port.

---
 rtl/decode_hazard_ctrl_pkg.sv | 40 ++++
 rtl/decode_hazard_ctrl_op_classify.sv | 52 +++++
 rtl/decode_hazard_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_decode_hazard_ctrl.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/decode_hazard_ctrl_pkg.sv
// Shared definitions for the decode-stage interlock: opcodes, instruction
// field positions, FSM state encoding and the op-class record.
package decode_pkg;

  // Opcodes recognised by the interlock; any other opcode behaves as a NOP.
  localparam logic [5:0] OP_ALU_R  = 6'h00;
  localparam logic [5:0] OP_ALU_I  = 6'h01;
  localparam logic [5:0] OP_LOAD   = 6'h08;
  localparam logic [5:0] OP_STORE  = 6'h09;
  localparam logic [5:0] OP_BRANCH = 6'h10;
  localparam logic [5:0] OP_HALT   = 6'h3F;

  // Instruction field positions in IR_id.
  localparam int OP_HI  = 31;
  localparam int OP_LO  = 26;
  localparam int RD_HI  = 25;
  localparam int RD_LO  = 21;
  localparam int RS1_HI = 20;
  localparam int RS1_LO = 16;
  localparam int RS2_HI = 15;
  localparam int RS2_LO = 11;

  // Issue-control FSM states.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHADOW = 2'd1,
    ST_HALTED = 2'd2
  } state_t;

  // Register usage of one instruction class.
  typedef struct packed {
    logic uses_rs1;
    logic uses_rs2;
    logic uses_rd_src;
    logic writes_rd;
    logic is_branch;
    logic is_halt;
  } op_class_t;

endpackage

// File: rtl/decode_hazard_ctrl_op_classify.sv
// Combinational opcode decoder: tells the interlock which register fields an
// instruction reads, whether it writes rd, and whether it is a branch or HALT.
module op_classify
  import decode_pkg::*;
(
  input  logic [5:0] op,
  output logic       uses_rs1,
  output logic       uses_rs2,
  output logic       uses_rd_src,
  output logic       writes_rd,
  output logic       is_branch,
  output logic       is_halt
);

  op_class_t cls;

  // Map opcode to register usage; unknown opcodes read and write nothing.
  always_comb begin
    cls = '0;
    case (op)
      OP_ALU_R: begin
        cls.uses_rs1  = 1'b1;
        cls.uses_rs2  = 1'b1;
        cls.writes_rd = 1'b1;
      end
      OP_ALU_I, OP_LOAD: begin
        cls.uses_rs1  = 1'b1;
        cls.writes_rd = 1'b1;
      end
      OP_STORE: begin
        cls.uses_rs1    = 1'b1;
        cls.uses_rd_src = 1'b1;
      end
      OP_BRANCH: begin
        cls.uses_rs1  = 1'b1;
        cls.is_branch = 1'b1;
      end
      OP_HALT: begin
        cls.is_halt = 1'b1;
      end
      default: cls = '0;
    endcase
  end

  assign uses_rs1    = cls.uses_rs1;
  assign uses_rs2    = cls.uses_rs2;
  assign uses_rd_src = cls.uses_rd_src;
  assign writes_rd   = cls.writes_rd;
  assign is_branch   = cls.is_branch;
  assign is_halt     = cls.is_halt;

endmodule

// File: rtl/decode_hazard_ctrl.sv
// Decode-stage interlock: per-register pending-write scoreboard, RAW and
// WAW-overflow stall, branch shadow and sticky HALT / writeback-error flags.
module decode_hazard_ctrl
  import decode_pkg::*;
#(
  parameter int NREG      = 32,
  parameter int CNT_W     = 2,
  parameter int BR_SHADOW = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            ir_valid,
  input  logic [31:0]     ir_id,
  input  logic            wb_valid,
  input  logic [4:0]      wb_rd,
  output logic            issue,
  output logic            stall,
  output logic [NREG-1:0] busy_mask,
  output logic            halted,
  output logic            wb_err
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam int               SH_W    = (BR_SHADOW > 1) ? $clog2(BR_SHADOW) : 1;

  logic [5:0] op;
  logic [4:0] rd;
  logic [4:0] rs1;
  logic [4:0] rs2;

  assign op  = ir_id[OP_HI:OP_LO];
  assign rd  = ir_id[RD_HI:RD_LO];
  assign rs1 = ir_id[RS1_HI:RS1_LO];
  assign rs2 = ir_id[RS2_HI:RS2_LO];

  logic uses_rs1;
  logic uses_rs2;
  logic uses_rd_src;
  logic writes_rd;
  logic is_branch;
  logic is_halt;

  op_classify u_op_classify (
    .op          (op),
    .uses_rs1    (uses_rs1),
    .uses_rs2    (uses_rs2),
    .uses_rd_src (uses_rd_src),
    .writes_rd   (writes_rd),
    .is_branch   (is_branch),
    .is_halt     (is_halt)
  );

  // Pending-write counters, one per register; r0 is hard-wired to zero.
  logic [CNT_W-1:0] cnt_bus [NREG];

  state_t          state_reg;
  state_t          state_next;
  logic [SH_W-1:0] shadow_cnt_reg;
  logic [SH_W-1:0] shadow_cnt_next;
  logic            wb_err_reg;

  // A source blocks issue while it has writes in flight, except when the
  // last outstanding write lands this very cycle (write-first bank bypass).
  function automatic logic src_blocked(input logic [4:0]       s,
                                       input logic [CNT_W-1:0] c,
                                       input logic             wv,
                                       input logic [4:0]       wr);
    return (s != 5'd0) && (c != '0) && !(wv && (wr == s) && (c == CNT_ONE));
  endfunction

  logic [CNT_W-1:0] cnt_rs1;
  logic [CNT_W-1:0] cnt_rs2;
  logic [CNT_W-1:0] cnt_rd;
  logic [CNT_W-1:0] cnt_wb;

  assign cnt_rs1 = cnt_bus[rs1];
  assign cnt_rs2 = cnt_bus[rs2];
  assign cnt_rd  = cnt_bus[rd];
  assign cnt_wb  = cnt_bus[wb_rd];

  logic raw_hazard;
  logic waw_overflow;

  assign raw_hazard = (uses_rs1    && src_blocked(rs1, cnt_rs1, wb_valid, wb_rd))
                   || (uses_rs2    && src_blocked(rs2, cnt_rs2, wb_valid, wb_rd))
                   || (uses_rd_src && src_blocked(rd,  cnt_rd,  wb_valid, wb_rd));

  // No bypass for WAW: a full counter must first drop before another write issues.
  assign waw_overflow = writes_rd && (rd != 5'd0) && (cnt_rd == CNT_MAX);

  assign stall  = ir_valid && ((state_reg != ST_IDLE) || raw_hazard || waw_overflow);
  assign issue  = ir_valid && !stall;
  assign halted = (state_reg == ST_HALTED);
  assign wb_err = wb_err_reg;

  logic inc_en;
  logic wb_hit;
  logic dec_en;
  logic err_set;

  assign inc_en  = issue && writes_rd && (rd != 5'd0);
  assign wb_hit  = wb_valid && (wb_rd != 5'd0);
  assign dec_en  = wb_hit && (cnt_wb != '0);
  assign err_set = wb_hit && (cnt_wb == '0);

  genvar gi;
  generate
    for (gi = 0; gi < NREG; gi++) begin : g_reg
      if (gi == 0) begin : g_r0
        assign cnt_bus[gi]   = '0;
        assign busy_mask[gi] = 1'b0;
      end else begin : g_cnt
        logic [CNT_W-1:0] cnt_reg;
        logic             inc_hit;
        logic             dec_hit;

        assign inc_hit = inc_en && (rd == 5'(gi));
        assign dec_hit = dec_en && (wb_rd == 5'(gi));

        // Count issued writes up and retired writebacks down; both at once cancel.
        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) begin
            cnt_reg <= '0;
          end else if (inc_hit && !dec_hit) begin
            cnt_reg <= cnt_reg + CNT_ONE;
          end else if (dec_hit && !inc_hit) begin
            cnt_reg <= cnt_reg - CNT_ONE;
          end
        end

        assign cnt_bus[gi]   = cnt_reg;
        assign busy_mask[gi] = |cnt_reg;
      end
    end
  endgenerate

  // FSM state and branch-shadow counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= ST_IDLE;
      shadow_cnt_reg <= '0;
    end else begin
      state_reg      <= state_next;
      shadow_cnt_reg <= shadow_cnt_next;
    end
  end

  // Next state: an issued branch opens a shadow of BR_SHADOW cycles, an issued HALT parks the FSM.
  always_comb begin
    state_next      = state_reg;
    shadow_cnt_next = shadow_cnt_reg;
    case (state_reg)
      ST_IDLE: begin
        if (issue && is_branch) begin
          state_next      = ST_SHADOW;
          shadow_cnt_next = SH_W'(BR_SHADOW - 1);
        end else if (issue && is_halt) begin
          state_next = ST_HALTED;
        end
      end
      ST_SHADOW: begin
        if (shadow_cnt_reg == '0) begin
          state_next = ST_IDLE;
        end else begin
          shadow_cnt_next = shadow_cnt_reg - SH_W'(1);
        end
      end
      ST_HALTED: state_next = ST_HALTED;
      default:   state_next = ST_IDLE;
    endcase
  end

  // Sticky flag: a writeback arrived for a register with nothing in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_err_reg <= 1'b0;
    end else if (err_set) begin
      wb_err_reg <= 1'b1;
    end
  end

endmodule

// File: tb/tb_decode_hazard_ctrl.sv
// Self-checking bench for decode_hazard_ctrl: a table of directed vectors,
// hand-written branch/halt/reset sequences, then random traffic compared
// against a pending-count reference model.
module tb_decode_hazard_ctrl;
  import decode_pkg::*;

  localparam int NREG      = 32;
  localparam int CNT_W     = 2;
  localparam int BR_SHADOW = 2;
  localparam int CMAX      = (1 << CNT_W) - 1;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            ir_valid = 1'b0;
  logic [31:0]     ir_id = '0;
  logic            wb_valid = 1'b0;
  logic [4:0]      wb_rd = '0;
  logic            issue;
  logic            stall;
  logic [NREG-1:0] busy_mask;
  logic            halted;
  logic            wb_err;

  decode_hazard_ctrl #(.NREG(NREG), .CNT_W(CNT_W), .BR_SHADOW(BR_SHADOW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ir_valid  (ir_valid),
    .ir_id     (ir_id),
    .wb_valid  (wb_valid),
    .wb_rd     (wb_rd),
    .issue     (issue),
    .stall     (stall),
    .busy_mask (busy_mask),
    .halted    (halted),
    .wb_err    (wb_err)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model: outstanding writes per register, remaining shadow cycles, flags.
  int pend [NREG];
  int shadow_left;
  bit m_halted;
  bit m_err;

  typedef struct {
    bit          iv;
    logic [31:0] ir;
    bit          wv;
    logic [4:0]  wr;
    bit          st;
    bit          is;
    logic [31:0] busy;
    bit          hl;
    bit          er;
  } vec_t;

  vec_t tbl[$];

  function automatic logic [31:0] mk(input logic [5:0] op, input logic [4:0] rd,
                                     input logic [4:0] rs1, input logic [4:0] rs2);
    return {op, rd, rs1, rs2, 11'd0};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic void model_reset();
    for (int r = 0; r < NREG; r++) pend[r] = 0;
    shadow_left = 0;
    m_halted    = 0;
    m_err       = 0;
  endfunction

  // Register usage straight from the op-class table.
  function automatic void classify(input logic [5:0] op, output bit r1, output bit r2,
                                   output bit rds, output bit wr, output bit br, output bit ht);
    r1 = 0; r2 = 0; rds = 0; wr = 0; br = 0; ht = 0;
    if (op == OP_ALU_R) begin r1 = 1; r2 = 1; wr = 1; end
    else if (op == OP_ALU_I || op == OP_LOAD) begin r1 = 1; wr = 1; end
    else if (op == OP_STORE) begin r1 = 1; rds = 1; end
    else if (op == OP_BRANCH) begin r1 = 1; br = 1; end
    else if (op == OP_HALT) ht = 1;
  endfunction

  function automatic bit src_waits(input int s, input bit wv, input int wr);
    if (s == 0 || pend[s] == 0) return 0;
    return !(wv && wr == s && pend[s] == 1);
  endfunction

  function automatic bit model_stall(input bit iv, input logic [31:0] ir, input bit wv, input logic [4:0] wr);
    bit r1, r2, rds, w, br, ht;
    int rd, s1, s2;
    if (!iv) return 0;
    if (shadow_left > 0 || m_halted) return 1;
    classify(ir[31:26], r1, r2, rds, w, br, ht);
    rd = int'(ir[25:21]); s1 = int'(ir[20:16]); s2 = int'(ir[15:11]);
    if (r1 && src_waits(s1, wv, int'(wr))) return 1;
    if (r2 && src_waits(s2, wv, int'(wr))) return 1;
    if (rds && src_waits(rd, wv, int'(wr))) return 1;
    if (w && rd != 0 && pend[rd] == CMAX) return 1;
    return 0;
  endfunction

  function automatic logic [31:0] model_busy();
    logic [31:0] b = '0;
    for (int r = 1; r < NREG; r++) b[r] = (pend[r] != 0);
    return b;
  endfunction

  // Advance the model by one clock edge.
  function automatic void model_commit(input bit iv, input logic [31:0] ir, input bit wv, input logic [4:0] wr);
    bit r1, r2, rds, w, br, ht, st, iss;
    int rd;
    st  = model_stall(iv, ir, wv, wr);
    iss = iv && !st;
    classify(ir[31:26], r1, r2, rds, w, br, ht);
    rd = int'(ir[25:21]);
    if (wv && wr != 0) begin
      if (pend[wr] != 0) pend[wr]--;
      else m_err = 1;
    end
    if (iss && w && rd != 0) pend[rd]++;
    if (shadow_left > 0) shadow_left--;
    if (iss && br) shadow_left = BR_SHADOW;
    if (iss && ht) m_halted = 1;
  endfunction

  task automatic drive(input bit iv, input logic [31:0] ir, input bit wv, input logic [4:0] wr);
    @(negedge clk);
    ir_valid = iv; ir_id = ir; wb_valid = wv; wb_rd = wr;
    #1;
  endtask

  // Compare all outputs against the model for the inputs currently applied, then advance it.
  task automatic check_model(input string tag);
    bit st;
    st = model_stall(ir_valid, ir_id, wb_valid, wb_rd);
    check({tag, "_stall"},  32'(stall),  32'(st));
    check({tag, "_issue"},  32'(issue),  32'(ir_valid && !st));
    check({tag, "_busy"},   busy_mask,   model_busy());
    check({tag, "_halted"}, 32'(halted), 32'(m_halted));
    check({tag, "_wb_err"}, 32'(wb_err), 32'(m_err));
    $display("%s ir_valid=%0b ir=%h wb=%0b/%0d stall=%0b issue=%0b busy=%h halted=%0b wb_err=%0b",
             tag, ir_valid, ir_id, wb_valid, wb_rd, stall, issue, busy_mask, halted, wb_err);
    model_commit(ir_valid, ir_id, wb_valid, wb_rd);
  endtask

  // Assert reset asynchronously (clock low) and verify the outputs clear at once.
  task automatic do_reset(input string tag);
    @(negedge clk);
    ir_valid = 0; ir_id = '0; wb_valid = 0; wb_rd = '0;
    #1 rst_n = 0;
    #1;
    check({tag, "_busy"},   busy_mask,   32'h0);
    check({tag, "_stall"},  32'(stall),  32'h0);
    check({tag, "_issue"},  32'(issue),  32'h0);
    check({tag, "_halted"}, 32'(halted), 32'h0);
    check({tag, "_wb_err"}, 32'(wb_err), 32'h0);
    $display("%s reset asserted", tag);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1;
    model_reset();
  endtask

  function automatic void add(input bit iv, input logic [31:0] ir, input bit wv, input logic [4:0] wr,
                              input bit st, input bit is, input logic [31:0] busy, input bit hl, input bit er);
    vec_t v;
    v.iv = iv; v.ir = ir; v.wv = wv; v.wr = wr;
    v.st = st; v.is = is; v.busy = busy; v.hl = hl; v.er = er;
    tbl.push_back(v);
  endfunction

  initial begin
    int hcount;
    bit iv, wv;
    logic [31:0] ir;
    logic [4:0] wr, rd, s1, s2;
    logic [5:0] op;
    int sel;

    // RAW stall with writeback bypass.
    add(1, mk(OP_ALU_R, 3, 1, 2), 0, 0, 0, 1, 32'h0,  0, 0);
    add(1, mk(OP_ALU_I, 4, 3, 0), 0, 0, 1, 0, 32'h8,  0, 0);
    add(1, mk(OP_ALU_I, 4, 3, 0), 0, 0, 1, 0, 32'h8,  0, 0);
    add(1, mk(OP_ALU_I, 4, 3, 0), 1, 3, 0, 1, 32'h8,  0, 0);
    add(0, 32'h0,                 0, 0, 0, 0, 32'h10, 0, 0);
    add(0, 32'h0,                 1, 4, 0, 0, 32'h10, 0, 0);
    // r0 is never tracked.
    add(1, mk(OP_LOAD, 0, 0, 0),  0, 0, 0, 1, 32'h0,  0, 0);
    add(1, mk(OP_ALU_R, 0, 0, 0), 0, 0, 0, 1, 32'h0,  0, 0);
    add(0, 32'h0,                 0, 0, 0, 0, 32'h0,  0, 0);
    // Counter saturation at 3 writes in flight to r5.
    add(1, mk(OP_ALU_I, 5, 0, 0), 0, 0, 0, 1, 32'h0,  0, 0);
    add(1, mk(OP_LOAD, 5, 0, 0),  0, 0, 0, 1, 32'h20, 0, 0);
    add(1, mk(OP_ALU_R, 5, 0, 0), 0, 0, 0, 1, 32'h20, 0, 0);
    add(1, mk(OP_ALU_I, 5, 0, 0), 0, 0, 1, 0, 32'h20, 0, 0);
    add(1, mk(OP_ALU_I, 5, 0, 0), 1, 5, 1, 0, 32'h20, 0, 0);
    add(1, mk(OP_ALU_I, 5, 0, 0), 0, 0, 0, 1, 32'h20, 0, 0);
    add(1, mk(OP_ALU_I, 5, 0, 0), 0, 0, 1, 0, 32'h20, 0, 0);
    add(0, 32'h0,                 1, 5, 0, 0, 32'h20, 0, 0);
    add(0, 32'h0,                 1, 5, 0, 0, 32'h20, 0, 0);
    add(0, 32'h0,                 1, 5, 0, 0, 32'h20, 0, 0);
    add(1, mk(OP_ALU_I, 6, 5, 0), 0, 0, 0, 1, 32'h0,  0, 0);
    // Stray writeback sets the sticky error; same-cycle inc/dec cancels.
    add(0, 32'h0,                 1, 7, 0, 0, 32'h40, 0, 0);
    add(0, 32'h0,                 0, 0, 0, 0, 32'h40, 0, 1);
    add(1, mk(OP_ALU_R, 4, 0, 0), 0, 0, 0, 1, 32'h40, 0, 1);
    add(1, mk(OP_ALU_I, 4, 0, 0), 1, 4, 0, 1, 32'h50, 0, 1);
    add(0, 32'h0,                 0, 0, 0, 0, 32'h50, 0, 1);
    // STORE reads rd as a source.
    add(1, mk(OP_STORE, 4, 0, 0), 0, 0, 1, 0, 32'h50, 0, 1);
    add(1, mk(OP_STORE, 4, 0, 0), 1, 4, 0, 1, 32'h50, 0, 1);
    add(0, 32'h0,                 1, 6, 0, 0, 32'h40, 0, 1);
    add(0, 32'h0,                 0, 0, 0, 0, 32'h0,  0, 1);

    model_reset();
    do_reset("rst0");

    foreach (tbl[i]) begin
      drive(tbl[i].iv, tbl[i].ir, tbl[i].wv, tbl[i].wr);
      check($sformatf("vec%0d_stall", i),  32'(stall),  32'(tbl[i].st));
      check($sformatf("vec%0d_issue", i),  32'(issue),  32'(tbl[i].is));
      check($sformatf("vec%0d_busy", i),   busy_mask,   tbl[i].busy);
      check($sformatf("vec%0d_halted", i), 32'(halted), 32'(tbl[i].hl));
      check($sformatf("vec%0d_wb_err", i), 32'(wb_err), 32'(tbl[i].er));
      $display("vec%0d ir=%h wb=%0b/%0d stall=%0b issue=%0b busy=%h wb_err=%0b",
               i, ir_id, wb_valid, wb_rd, stall, issue, busy_mask, wb_err);
      model_commit(tbl[i].iv, tbl[i].ir, tbl[i].wv, tbl[i].wr);
    end

    // Branch shadow: exactly BR_SHADOW stall cycles, then issue.
    do_reset("rst1");
    drive(1, mk(OP_BRANCH, 0, 0, 0), 0, 0);
    check("br_issue", 32'(issue), 32'h1);
    model_commit(ir_valid, ir_id, wb_valid, wb_rd);
    for (int k = 0; k < BR_SHADOW; k++) begin
      drive(1, mk(OP_ALU_R, 1, 0, 0), 0, 0);
      check($sformatf("shadow%0d_stall", k), 32'(stall), 32'h1);
      check($sformatf("shadow%0d_issue", k), 32'(issue), 32'h0);
      $display("shadow cycle %0d stall=%0b issue=%0b", k, stall, issue);
      model_commit(ir_valid, ir_id, wb_valid, wb_rd);
    end
    drive(1, mk(OP_ALU_R, 1, 0, 0), 0, 0);
    check("post_shadow_issue", 32'(issue), 32'h1);
    model_commit(ir_valid, ir_id, wb_valid, wb_rd);

    // HALT: sticky stall, scoreboard still drains.
    drive(1, mk(OP_HALT, 0, 0, 0), 1, 1);
    check("halt_issue", 32'(issue), 32'h1);
    model_commit(ir_valid, ir_id, wb_valid, wb_rd);
    for (int k = 0; k < 4; k++) begin
      drive(1, mk(OP_ALU_R, 2, 0, 0), 0, 0);
      check($sformatf("halted%0d_flag", k),  32'(halted), 32'h1);
      check($sformatf("halted%0d_stall", k), 32'(stall),  32'h1);
      check($sformatf("halted%0d_busy", k),  busy_mask,   32'h0);
      $display("halted cycle %0d stall=%0b halted=%0b busy=%h", k, stall, halted, busy_mask);
      model_commit(ir_valid, ir_id, wb_valid, wb_rd);
    end
    do_reset("rst_halt");
    drive(1, mk(OP_ALU_R, 2, 0, 0), 0, 0);
    check("after_halt_rst_issue", 32'(issue), 32'h1);
    model_commit(ir_valid, ir_id, wb_valid, wb_rd);

    // Reset in the middle of a branch shadow.
    drive(1, mk(OP_BRANCH, 0, 0, 0), 0, 0);
    model_commit(ir_valid, ir_id, wb_valid, wb_rd);
    drive(1, mk(OP_ALU_I, 3, 0, 0), 0, 0);
    check("mid_shadow_stall", 32'(stall), 32'h1);
    model_commit(ir_valid, ir_id, wb_valid, wb_rd);
    do_reset("rst_shadow");
    drive(1, mk(OP_ALU_I, 3, 0, 0), 0, 0);
    check("after_shadow_rst_issue", 32'(issue), 32'h1);
    check("after_shadow_rst_stall", 32'(stall), 32'h0);
    model_commit(ir_valid, ir_id, wb_valid, wb_rd);

    // Random traffic against the model.
    do_reset("rst_rand");
    hcount = 0;
    for (int k = 0; k < 800; k++) begin
      if (k % 200 == 199 || hcount > 8) begin
        do_reset($sformatf("rst_r%0d", k));
        hcount = 0;
      end
      iv  = ($urandom % 4) != 0;
      sel = int'($urandom % 16);
      if (sel < 4)        op = OP_ALU_R;
      else if (sel < 7)   op = OP_ALU_I;
      else if (sel < 9)   op = OP_LOAD;
      else if (sel < 11)  op = OP_STORE;
      else if (sel == 11) op = OP_BRANCH;
      else if (sel == 12) op = (($urandom % 8) == 0) ? OP_HALT : OP_ALU_I;
      else                op = 6'($urandom);
      rd = 5'($urandom % 6);
      s1 = 5'($urandom % 6);
      s2 = 5'($urandom % 6);
      ir = mk(op, rd, s1, s2);
      wv = ($urandom % 2) != 0;
      wr = (($urandom % 8) != 0) ? 5'($urandom % 6) : 5'($urandom);
      drive(iv, ir, wv, wr);
      check_model($sformatf("rnd%0d", k));
      if (m_halted) hcount++;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
